// File: rtl/tempo_control.sv
`default_nettype none
// ============================================================================
// Module      : tempo_control
// Description : Metronome tempo controller. Owns the BPM register and turns
//               debounced UP/DOWN button levels and press pulses into single
//               steps, hold-to-auto-repeat steps and a both-buttons return to
//               the default tempo.
//               Optional feature macro: TEMPO_ACCEL_EN (accelerated repeat
//               step after ACCEL_REPEATS repeat steps).
// Revision    : 1.0 - initial release
// ============================================================================
module tempo_control #(
    parameter int BPM_MIN       = 30,
    parameter int BPM_MAX       = 240,
    parameter int BPM_DEFAULT   = 120,
    parameter int HOLD_CYCLES   = 6_000_000,
    parameter int REPEAT_CYCLES = 1_200_000,
    parameter int ACCEL_REPEATS = 10,
    parameter int ACCEL_STEP    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up_state,
    input  logic       up_pressed,
    input  logic       down_state,
    input  logic       down_pressed,
    output logic [7:0] bpm,
    output logic       bpm_changed,
    output logic       repeating
);

    // Counter sized for the longer of the two intervals.
    localparam int c_CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST   = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_REPEAT_LAST = c_CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

    localparam logic [7:0] c_BPM_MIN     = 8'(BPM_MIN);
    localparam logic [7:0] c_BPM_MAX     = 8'(BPM_MAX);
    localparam logic [7:0] c_BPM_DEFAULT = 8'(BPM_DEFAULT);

    localparam logic [2:0] c_S_IDLE        = 3'd0;
    localparam logic [2:0] c_S_HOLD_UP     = 3'd1;
    localparam logic [2:0] c_S_REPEAT_UP   = 3'd2;
    localparam logic [2:0] c_S_HOLD_DOWN   = 3'd3;
    localparam logic [2:0] c_S_REPEAT_DOWN = 3'd4;
    localparam logic [2:0] c_S_BOTH        = 3'd5;

    // Reject parameter sets the datapath cannot represent.
    if (BPM_MAX > 255 || BPM_MIN > BPM_DEFAULT || BPM_DEFAULT > BPM_MAX ||
        HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 ||
        ACCEL_REPEATS < 0 || ACCEL_REPEATS > 255 ||
        ACCEL_STEP < 1 || ACCEL_STEP > 255) begin : g_param_check
        $error("tempo_control: invalid parameter set");
    end

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_bpm;
    logic               r_changed;
    logic               r_repeating;

    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [7:0]         w_bpm_nxt;
    logic [7:0]         w_step;
    logic [7:0]         w_bpm_up;
    logic [7:0]         w_bpm_dn;
    logic               w_in_repeat;
    logic               w_dir_up;
    logic               w_own;
    logic               w_other;
    logic               w_expire;
    logic               w_nxt_repeat;

    // Saturating increment, evaluated at 9 bits so it cannot wrap.
    function automatic logic [7:0] f_step_up(input logic [7:0] cur, input logic [7:0] s);
        logic [8:0] sum;
        sum = {1'b0, cur} + {1'b0, s};
        if (sum > {1'b0, c_BPM_MAX})
            return c_BPM_MAX;
        return sum[7:0];
    endfunction

    // Saturating decrement; the comparison avoids ever forming a negative value.
    function automatic logic [7:0] f_step_dn(input logic [7:0] cur, input logic [7:0] s);
        if ({1'b0, cur} < ({1'b0, s} + {1'b0, c_BPM_MIN}))
            return c_BPM_MIN;
        return cur - s;
    endfunction

    assign w_in_repeat  = (r_state == c_S_REPEAT_UP) || (r_state == c_S_REPEAT_DOWN);
    assign w_dir_up     = (r_state == c_S_HOLD_UP)   || (r_state == c_S_REPEAT_UP);
    assign w_own        = w_dir_up ? up_state : down_state;
    assign w_other      = w_dir_up ? down_state : up_state;
    assign w_expire     = w_in_repeat ? (r_cnt == c_REPEAT_LAST) : (r_cnt == c_HOLD_LAST);
    assign w_nxt_repeat = (w_state_nxt == c_S_REPEAT_UP) || (w_state_nxt == c_S_REPEAT_DOWN);
    assign w_bpm_up     = f_step_up(r_bpm, w_step);
    assign w_bpm_dn     = f_step_dn(r_bpm, w_step);

`ifdef TEMPO_ACCEL_EN
    logic [7:0] r_rep;
    logic [7:0] w_rep_nxt;

    // Step size: the repeat step that takes rep past ACCEL_REPEATS is the
    // first accelerated one, hence the >= on the pre-increment value.
    always_comb begin
        w_step = 8'd1;
        if (w_in_repeat && (r_rep >= 8'(ACCEL_REPEATS)))
            w_step = 8'(ACCEL_STEP);
    end

    // Repeat counter: 1 on the first repeat step, saturating count after,
    // cleared whenever the machine is not going to a repeat state.
    always_comb begin
        w_rep_nxt = r_rep;
        if (!w_nxt_repeat)
            w_rep_nxt = 8'd0;
        else if (!w_in_repeat)
            w_rep_nxt = 8'd1;
        else if (w_expire && (r_rep != 8'hFF))
            w_rep_nxt = r_rep + 8'd1;
    end

    // Repeat-count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_rep <= 8'd0;
        else
            r_rep <= w_rep_nxt;
    end
`else
    // Fixed single-step size.
    always_comb begin
        w_step = 8'd1;
    end
`endif

    // Next-state logic; in the hold/repeat states the release and the
    // other-button checks take priority over the interval expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bpm_nxt   = r_bpm;
        case (r_state)
            c_S_IDLE: begin
                if (up_pressed && down_pressed) begin
                    w_state_nxt = c_S_BOTH;
                    w_bpm_nxt   = c_BPM_DEFAULT;
                end else if (up_pressed) begin
                    w_state_nxt = c_S_HOLD_UP;
                    w_bpm_nxt   = w_bpm_up;
                    w_cnt_nxt   = '0;
                end else if (down_pressed) begin
                    w_state_nxt = c_S_HOLD_DOWN;
                    w_bpm_nxt   = w_bpm_dn;
                    w_cnt_nxt   = '0;
                end
            end
            c_S_HOLD_UP, c_S_REPEAT_UP, c_S_HOLD_DOWN, c_S_REPEAT_DOWN: begin
                if (!w_own) begin
                    w_state_nxt = c_S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_other) begin
                    w_state_nxt = c_S_BOTH;
                    w_bpm_nxt   = c_BPM_DEFAULT;
                    w_cnt_nxt   = '0;
                end else if (w_expire) begin
                    w_state_nxt = w_dir_up ? c_S_REPEAT_UP : c_S_REPEAT_DOWN;
                    w_bpm_nxt   = w_dir_up ? w_bpm_up : w_bpm_dn;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            c_S_BOTH: begin
                if (!up_state && !down_state)
                    w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter, tempo and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_bpm       <= c_BPM_DEFAULT;
            r_changed   <= 1'b0;
            r_repeating <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bpm       <= w_bpm_nxt;
            r_changed   <= (w_bpm_nxt != r_bpm);
            r_repeating <= w_nxt_repeat;
        end
    end

    assign bpm         = r_bpm;
    assign bpm_changed = r_changed;
    assign repeating   = r_repeating;

endmodule
`default_nettype wire
